// File: rtl/midori_rand_gen_if.sv
// Seed handshake and randomness bus between the seed/TRNG port and midori_rand_gen.
interface midori_rand_gen_if #(
  parameter int NUM_SBOX = 16,
  parameter int RAND_W   = 96
);
  logic [31:0]                 seed_i;
  logic                        seed_valid_i;
  logic                        seed_ready_o;
  logic                        r_en_i;
  logic                        r_valid_o;
  logic [NUM_SBOX*RAND_W-1:0]  r_o;

  modport slave  (input  seed_i, seed_valid_i, r_en_i,
                  output seed_ready_o, r_valid_o, r_o);
  modport master (output seed_i, seed_valid_i, r_en_i,
                  input  seed_ready_o, r_valid_o, r_o);
endinterface

// File: rtl/midori_rand_gen.sv
// Per-S-box fresh-randomness LFSR bank for masked Midori, seeded over a 32-bit handshake.
// Optional MIDORI_RESEED_EN: accept a new seed load while in RUN.
module midori_rand_lane #(
  parameter int RAND_W = 96
) (
  input  logic [RAND_W-1:0] cur_i,
  input  logic [RAND_W-1:0] ld_i,
  output logic [RAND_W-1:0] adv_o,
  output logic [RAND_W-1:0] ld_g_o
);
  logic [RAND_W-1:0] s;

  // RAND_W lane steps unrolled into one combinational advance
  always_comb begin
    s = cur_i;
    for (int k = 0; k < RAND_W; k++)
      s = {s[RAND_W-2:0], s[95] ^ s[93] ^ s[48] ^ s[46]};
    adv_o = s;
  end

  always_comb begin
    ld_g_o = ld_i;
    if (ld_i == '0) ld_g_o[0] = 1'b1;
  end
endmodule

module midori_rand_gen #(
  parameter int NUM_SBOX   = 16,
  parameter int RAND_W     = 96,
  parameter int WARMUP_CYC = 4
) (
  input logic              clk,
  input logic              rst,
  midori_rand_gen_if.slave bus
);
  localparam int N          = NUM_SBOX * RAND_W;
  localparam int SEED_WORDS = N / 32;
  localparam int CNT_W      = $clog2(SEED_WORDS + 1);
  localparam int WC_W       = (WARMUP_CYC > 0) ? $clog2(WARMUP_CYC + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEED_WORDS);
  localparam logic [WC_W-1:0]  WC_LAST  = WC_W'((WARMUP_CYC > 0) ? WARMUP_CYC - 1 : 0);

  typedef enum logic [1:0] {IDLE, SEED, WARMUP, RUN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_nxt;
  logic [WC_W-1:0]  wcnt_q, wcnt_d;
  logic [N-1:0]     s_q, s_d, loaded, loaded_g, adv;
  logic             seed_ready, r_valid, accept;

  assign loaded = {s_q[N-33:0], bus.seed_i};

  for (genvar i = 0; i < NUM_SBOX; i++) begin : g_lane
    midori_rand_lane #(.RAND_W(RAND_W)) u_lane (
      .cur_i  (s_q[i*RAND_W +: RAND_W]),
      .ld_i   (loaded[i*RAND_W +: RAND_W]),
      .adv_o  (adv[i*RAND_W +: RAND_W]),
      .ld_g_o (loaded_g[i*RAND_W +: RAND_W])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      wcnt_q  <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wcnt_q  <= wcnt_d;
      s_q     <= s_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    wcnt_d     = wcnt_q;
    s_d        = s_q;
    seed_ready = 1'b0;
    r_valid    = 1'b0;
    cnt_nxt    = CNT_ONE;
    case (state_q)
      IDLE, SEED: seed_ready = 1'b1;
      WARMUP: begin
        s_d    = adv;
        wcnt_d = wcnt_q + 1'b1;
        if (wcnt_q == WC_LAST) state_d = RUN;
      end
      default: begin
        r_valid = 1'b1;
`ifdef MIDORI_RESEED_EN
        seed_ready = 1'b1;
`endif
        if (bus.r_en_i) s_d = adv;
      end
    endcase

    // An accepted word overrides any RUN advance in the same cycle
    accept = seed_ready & bus.seed_valid_i;
    if (accept) begin
      if (state_q == SEED) cnt_nxt = cnt_q + 1'b1;
      if (cnt_nxt == CNT_LAST) begin
        s_d     = loaded_g;
        cnt_d   = '0;
        wcnt_d  = '0;
        state_d = (WARMUP_CYC > 0) ? WARMUP : RUN;
      end else begin
        s_d     = loaded;
        cnt_d   = cnt_nxt;
        state_d = SEED;
      end
    end
  end

  assign bus.r_o          = s_q;
  assign bus.seed_ready_o = seed_ready;
  assign bus.r_valid_o    = r_valid;
endmodule

// File: tb/tb_midori_rand_gen.sv
// Directed/randomized bench: a 1-lane no-warmup instance and a default 16-lane instance.
module tb_midori_rand_gen;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_fail = 0;

`ifdef MIDORI_RESEED_EN
  localparam bit RUN_READY = 1'b1;
`else
  localparam bit RUN_READY = 1'b0;
`endif

  always #5 clk = ~clk;

  midori_rand_gen_if #(.NUM_SBOX(1),  .RAND_W(96)) ifa ();
  midori_rand_gen_if #(.NUM_SBOX(16), .RAND_W(96)) ifb ();

  midori_rand_gen #(.NUM_SBOX(1), .RAND_W(96), .WARMUP_CYC(0)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa.slave));
  midori_rand_gen #(.NUM_SBOX(16), .RAND_W(96), .WARMUP_CYC(4)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb.slave));

  logic [31:0] w [48];
  logic [95:0] mb [16];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Spec lane step applied 96 times: one full advance
  function automatic logic [95:0] adv96(input logic [95:0] s);
    for (int k = 0; k < 96; k++) s = {s[94:0], s[95] ^ s[93] ^ s[48] ^ s[46]};
    return s;
  endfunction

  // First word ends up highest: lane i holds words 45-3i .. 47-3i, zero-guarded
  task automatic build_b(input int adv_n);
    for (int i = 0; i < 16; i++) begin
      mb[i] = {w[45-3*i], w[46-3*i], w[47-3*i]};
      if (mb[i] == '0) mb[i] = 96'h1;
      for (int a = 0; a < adv_n; a++) mb[i] = adv96(mb[i]);
    end
  endtask

  task automatic chk_b_lanes(input string tag);
    for (int i = 0; i < 16; i++) chk(tag, ifb.r_o[i*96 +: 96], mb[i]);
  endtask

  task automatic feed_b(input int first, input int last);
    for (int i = first; i <= last; i++) begin
      int gaps = $urandom_range(0, 2);
      ifb.seed_valid_i = 1'b0;
      repeat (gaps) begin
        tick();
        chk("b_ready_gap", ifb.seed_ready_o, 1'b1);
      end
      ifb.seed_i = w[i];
      ifb.seed_valid_i = 1'b1;
      tick();
    end
    ifb.seed_valid_i = 1'b0;
  endtask

  initial begin
    logic [95:0] ma, prev;
    logic [31:0] rw;
    bit e;

    // reset with inputs active
    ifa.seed_i = $urandom; ifa.seed_valid_i = 1'b1; ifa.r_en_i = 1'b1;
    ifb.seed_i = $urandom; ifb.seed_valid_i = 1'b1; ifb.r_en_i = 1'b1;
    tick(); tick();
    chk("rst_valid_a", ifa.r_valid_o, 1'b0);
    chk("rst_ready_a", ifa.seed_ready_o, 1'b1);
    chk("rst_r_a", ifa.r_o, 96'h0);
    chk("rst_valid_b", ifb.r_valid_o, 1'b0);
    chk("rst_ready_b", ifb.seed_ready_o, 1'b1);
    chk("rst_r_b15", ifb.r_o[15*96 +: 96], 96'h0);
    ifa.seed_valid_i = 1'b0; ifa.r_en_i = 1'b0;
    ifb.seed_valid_i = 1'b0; ifb.r_en_i = 1'b0;
    rst = 1'b0;
    tick();
    chk("post_rst_r_a", ifa.r_o, 96'h0);

    // zero guard
    for (int k = 0; k < 3; k++) begin
      ifa.seed_i = 32'h0; ifa.seed_valid_i = 1'b1;
      tick();
      if (k < 2) chk("zg_valid_early", ifa.r_valid_o, 1'b0);
    end
    ifa.seed_valid_i = 1'b0;
    chk("zg_valid", ifa.r_valid_o, 1'b1);
    chk("zg_r", ifa.r_o, 96'h1);
    chk("zg_ready_run", ifa.seed_ready_o, RUN_READY);

    // normal seeding
    rst = 1'b1; tick(); rst = 1'b0;
    ifa.seed_valid_i = 1'b1;
    ifa.seed_i = 32'hDEADBEEF; tick();
    ifa.seed_i = 32'h01234567; tick();
    ifa.seed_i = 32'h89ABCDEF; tick();
    ifa.seed_valid_i = 1'b0;
    ma = 96'hDEADBEEF_01234567_89ABCDEF;
    chk("seed_valid", ifa.r_valid_o, 1'b1);
    for (int c = 0; c < 10; c++) begin
      chk("seed_hold", ifa.r_o, ma);
      tick();
    end

    // advance
    ifa.r_en_i = 1'b1; tick(); ifa.r_en_i = 1'b0;
    ma = adv96(ma);
    chk("adv_one", ifa.r_o, ma);
    for (int c = 0; c < 5; c++) begin
      prev = ma;
      ifa.r_en_i = 1'b1; tick();
      ma = adv96(ma);
      chk("adv_burst", ifa.r_o, ma);
      chk("adv_distinct", (ifa.r_o !== prev), 1'b1);
      chk("adv_nonzero", (ifa.r_o !== 96'h0), 1'b1);
    end
    for (int c = 0; c < 20; c++) begin
      e = 1'($urandom_range(0, 1));
      ifa.r_en_i = e; tick();
      if (e) ma = adv96(ma);
      chk("adv_rand", ifa.r_o, ma);
    end

    // seed word offered in RUN
    rw = $urandom;
    ifa.seed_i = rw; ifa.seed_valid_i = 1'b1; ifa.r_en_i = RUN_READY;
    tick();
    ifa.seed_valid_i = 1'b0; ifa.r_en_i = 1'b0;
`ifdef MIDORI_RESEED_EN
    chk("reseed_valid", ifa.r_valid_o, 1'b0);
    chk("reseed_r", ifa.r_o, {ma[63:0], rw});
    chk("reseed_ready", ifa.seed_ready_o, 1'b1);
`else
    chk("noreseed_valid", ifa.r_valid_o, 1'b1);
    chk("noreseed_r", ifa.r_o, ma);
`endif

    // 16-lane warmup
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 48; i++) w[i] = $urandom;
    feed_b(0, 47);
    chk("wu_ready", ifb.seed_ready_o, 1'b0);
    chk("wu_valid0", ifb.r_valid_o, 1'b0);
    for (int c = 1; c <= 4; c++) begin
      tick();
      chk("wu_valid", ifb.r_valid_o, (c == 4));
    end
    build_b(4);
    chk_b_lanes("wu_lane");
    chk("wu_ready_run", ifb.seed_ready_o, RUN_READY);
    ifb.r_en_i = 1'b1; tick(); ifb.r_en_i = 1'b0;
    build_b(5);
    chk_b_lanes("wu_adv_lane");

    // reset during word 20
    rst = 1'b1; tick(); rst = 1'b0;
    feed_b(0, 18);
    ifb.seed_i = $urandom; ifb.seed_valid_i = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; ifb.seed_valid_i = 1'b0;
    chk("mid_rst_ready", ifb.seed_ready_o, 1'b1);
    chk("mid_rst_valid", ifb.r_valid_o, 1'b0);
    chk("mid_rst_r0", ifb.r_o[95:0], 96'h0);
    chk("mid_rst_r15", ifb.r_o[15*96 +: 96], 96'h0);
    for (int i = 0; i < 48; i++) w[i] = $urandom;
    feed_b(0, 46);
    repeat (4) tick();
    chk("mid_rst_47_valid", ifb.r_valid_o, 1'b0);
    chk("mid_rst_47_ready", ifb.seed_ready_o, 1'b1);
    feed_b(47, 47);
    repeat (4) tick();
    chk("mid_rst_full_valid", ifb.r_valid_o, 1'b1);
    build_b(4);
    chk_b_lanes("mid_rst_lane");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
